// File: rtl/corescore_uart_tx.sv
// corescore_uart_tx
//   8N1 UART transmitter fed by an AXI4-Stream byte source. It optionally
//   appends CR LF after every byte accepted with tlast, so collected text
//   reaches the host terminal line by line.
//
// Parameters
//   clk_freq_hz : frequency of i_clk in Hz
//   baud_rate   : serial bit rate; DIV = clk_freq_hz / baud_rate (must be >= 2)
//   append_eol  : 1 = send 0x0D, 0x0A after each tlast byte
//
// Ports
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_tdata   : byte to transmit
//   i_tlast   : end of message (used only when append_eol = 1)
//   i_tvalid  : upstream byte valid
//   o_tready  : block can accept a byte (idle, no EOL pending)
//   o_uart_tx : serial line, idle high, registered
//   o_busy    : frame or EOL sequence in progress
module corescore_uart_tx #(
  parameter int clk_freq_hz = 16000000,
  parameter int baud_rate   = 57600,
  parameter bit append_eol  = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam int              DIV      = clk_freq_hz / baud_rate;
  localparam int              CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [7:0]      EOL_CR   = 8'h0D;
  localparam logic [7:0]      EOL_LF   = 8'h0A;

  generate
    if (DIV < 2) begin : g_div_check
      $error("corescore_uart_tx: clk_freq_hz / baud_rate must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic             eol_req_q, eol_req_d;
  logic [1:0]       pend_q, pend_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             accept;
  logic             bit_end;

  assign o_tready  = (state_q == IDLE) && (pend_q == 2'd0) && !i_rst;
  assign o_busy    = (state_q != IDLE) || (pend_q != 2'd0);
  assign o_uart_tx = tx_q;
  assign accept    = i_tvalid && o_tready;
  assign bit_end   = (baud_q == DIV_LAST);

  // Next-state: the baud counter restarts on every bit boundary, so frames
  // never accumulate drift. pend_q counts EOL bytes not yet completed: it is
  // 2 while CR is on the line and 1 while LF is on the line.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    eol_req_d = eol_req_q;
    pend_d    = pend_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (accept) begin
          shift_d   = i_tdata;
          eol_req_d = append_eol && i_tlast;
          bit_d     = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (eol_req_q) begin
            eol_req_d = 1'b0;
            pend_d    = 2'd2;
            shift_d   = EOL_CR;
            state_d   = START;
          end else if (pend_q == 2'd2) begin
            pend_d  = 2'd1;
            shift_d = EOL_LF;
            state_d = START;
          end else begin
            pend_d  = 2'd0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is registered from the next state so the start bit
    // appears in the cycle right after the accepting edge.
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end else begin
      tx_d = 1'b1;
    end
  end

  // Control registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= 3'd0;
      eol_req_q <= 1'b0;
      pend_q    <= 2'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      eol_req_q <= eol_req_d;
      pend_q    <= pend_d;
      tx_q      <= tx_d;
    end
  end

  // Data register: only meaningful after a load, so it carries no reset
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_corescore_uart_tx.sv
module tb_corescore_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tlast = 1'b0;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic       tready_a, tx_a, busy_a;
  logic       tready_b, tx_b, busy_b;
  logic       line;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT a: no EOL insertion, DUT b: EOL insertion. Only one transmits at a time.
  corescore_uart_tx #(.clk_freq_hz(1000), .baud_rate(100), .append_eol(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(valid_a),
    .o_tready(tready_a), .o_uart_tx(tx_a), .o_busy(busy_a)
  );

  corescore_uart_tx #(.clk_freq_hz(1000), .baud_rate(100), .append_eol(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(valid_b),
    .o_tready(tready_b), .o_uart_tx(tx_b), .o_busy(busy_b)
  );

  assign line = tx_a & tx_b;

  // Host-side decoder: samples mid-bit (DIV = 10), pushes {start_ok, stop, byte}
  logic [9:0] rx_q[$];
  logic [9:0] exp_q[$];
  int         start_q[$];
  bit         m_busy = 1'b0;
  int         m_cnt = 0;
  logic       m_start_ok = 1'b0;
  logic [7:0] m_sh = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (line === 1'b0) begin
        m_busy <= 1'b1;
        m_cnt  <= 2;
        start_q.push_back(cyc);
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 5) m_start_ok <= (line === 1'b0);
      if (m_cnt >= 15 && m_cnt <= 85 && (m_cnt % 10) == 5) m_sh[3'((m_cnt - 15) / 10)] <= line;
      if (m_cnt == 95) begin
        rx_q.push_back({m_start_ok, line, m_sh});
        m_busy <= 1'b0;
      end
    end
  end

  task automatic send(input bit use_b, input logic [7:0] d, input bit last, input bit hold,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    tdata = d;
    tlast = last;
    if (use_b) valid_b = 1'b1;
    else valid_a = 1'b1;
    while (((use_b ? tready_b : tready_a) !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL send_timeout: tready never rose for byte %h, required 1 within 2000 cycles", d);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) begin
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  task automatic wait_rx(input int count);
    int n;
    n = 0;
    while (rx_q.size() < count && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (tready_a !== 1'b0 || tready_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_tready: got a=%b b=%b, required 0 while in reset", tready_a, tready_b);
    end
    tests++;
    if (tx_a !== 1'b1 || tx_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_line: got tx=%b%b busy=%b%b, required tx=11 busy=00",
               tx_a, tx_b, busy_a, busy_b);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests++;
      if (tx_a !== 1'b1 || tready_a !== 1'b1 || busy_a !== 1'b0 ||
          tx_b !== 1'b1 || tready_b !== 1'b1 || busy_b !== 1'b0) begin
        fails++;
        $display("FAIL idle_cycle%0d: got tx=%b%b tready=%b%b busy=%b%b, required 11/11/00",
                 i, tx_a, tx_b, tready_a, tready_b, busy_a, busy_b);
      end
    end
  endtask

  task automatic test_single_a5;
    int acc, bad, low;
    logic [9:0] frame;
    logic [9:0] e, r;
    frame = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    low = 0;
    exp_q.push_back({2'b11, 8'hA5});
    send(1'b0, 8'hA5, 1'b0, 1'b0, acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== frame[i / 10]) bad++;
      if (tready_a === 1'b0) low++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL a5_line: %0d cycles had wrong line level, required 0", bad);
    end
    tests++;
    if (low !== 100) begin
      fails++;
      $display("FAIL a5_tready_low: low for %0d of 100 frame cycles, required 100", low);
    end
    @(negedge clk);
    tests++;
    if (tready_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL a5_tready_back: got tready=%b busy=%b, required 1/0", tready_a, busy_a);
    end
    wait_rx(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (rx_q.size() == 0) begin
        fails++;
        $display("FAIL a5_decode: no byte decoded, required %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r !== e) begin
          fails++;
          $display("FAIL a5_decode: got %h, required %h", r, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int a0, a1;
    logic [9:0] e, r;
    start_q.delete();
    exp_q.push_back({2'b11, 8'h41});
    exp_q.push_back({2'b11, 8'h42});
    send(1'b0, 8'h41, 1'b0, 1'b1, a0);
    send(1'b0, 8'h42, 1'b0, 1'b0, a1);
    tests++;
    if (a1 - a0 !== 101) begin
      fails++;
      $display("FAIL b2b_accept_gap: got %0d cycles, required 101", a1 - a0);
    end
    wait_rx(2);
    tests++;
    if (start_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_starts: got %0d start bits, required 2", start_q.size());
    end else if (start_q[1] - start_q[0] !== 101 || start_q[0] !== a0) begin
      fails++;
      $display("FAIL b2b_starts: got gap %0d first %0d, required gap 101 first %0d",
               start_q[1] - start_q[0], start_q[0], a0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (rx_q.size() == 0) begin
        fails++;
        $display("FAIL b2b_decode: no byte decoded, required %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r !== e) begin
          fails++;
          $display("FAIL b2b_decode: got %h, required %h", r, e);
        end
      end
    end
  endtask

  task automatic test_eol;
    int acc, low, notbusy;
    logic [9:0] e, r;
    start_q.delete();
    low = 0;
    notbusy = 0;
    exp_q.push_back({2'b11, 8'h58});
    exp_q.push_back({2'b11, 8'h0D});
    exp_q.push_back({2'b11, 8'h0A});
    send(1'b1, 8'h58, 1'b1, 1'b0, acc);
    @(negedge clk);
    while (tready_b !== 1'b1 && low < 1000) begin
      low++;
      if (busy_b !== 1'b1) notbusy++;
      @(negedge clk);
    end
    tests++;
    if (low !== 300) begin
      fails++;
      $display("FAIL eol_tready_low: got %0d cycles, required 300", low);
    end
    tests++;
    if (notbusy !== 0) begin
      fails++;
      $display("FAIL eol_busy: busy low on %0d cycles, required 0", notbusy);
    end
    wait_rx(3);
    tests++;
    if (start_q.size() != 3) begin
      fails++;
      $display("FAIL eol_starts: got %0d start bits, required 3", start_q.size());
    end else if (start_q[1] - start_q[0] !== 100 || start_q[2] - start_q[1] !== 100) begin
      fails++;
      $display("FAIL eol_starts: got gaps %0d %0d, required 100 100",
               start_q[1] - start_q[0], start_q[2] - start_q[1]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (rx_q.size() == 0) begin
        fails++;
        $display("FAIL eol_decode: no byte decoded, required %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r !== e) begin
          fails++;
          $display("FAIL eol_decode: got %h, required %h", r, e);
        end
      end
    end
  endtask

  task automatic test_no_eol;
    int acc, low;
    logic [9:0] e, r;
    low = 0;
    exp_q.push_back({2'b11, 8'h33});
    send(1'b0, 8'h33, 1'b1, 1'b0, acc);
    @(negedge clk);
    while (tready_a !== 1'b1 && low < 1000) begin
      low++;
      @(negedge clk);
    end
    tests++;
    if (low !== 100) begin
      fails++;
      $display("FAIL noeol_tready_low: got %0d cycles, required 100", low);
    end
    repeat (300) @(negedge clk);
    tests++;
    if (rx_q.size() != 1 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL noeol_count: got %0d bytes busy=%b, required 1 byte busy=0", rx_q.size(), busy_a);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (rx_q.size() == 0) begin
        fails++;
        $display("FAIL noeol_decode: no byte decoded, required %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r !== e) begin
          fails++;
          $display("FAIL noeol_decode: got %h, required %h", r, e);
        end
      end
    end
    rx_q.delete();
  endtask

  task automatic test_reset_mid;
    int acc, bad;
    logic [9:0] e, r;
    bad = 0;
    send(1'b0, 8'h0F, 1'b0, 1'b0, acc);
    repeat (55) @(negedge clk);
    tests++;
    if (tx_a !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_bit4: got line %b before reset, required 0", tx_a);
    end
    #2 rst = 1'b1;
    @(negedge clk);
    tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || tready_a !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_abort: got tx=%b busy=%b tready=%b, required 1/0/0", tx_a, busy_a, tready_a);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (tready_a !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_tready: got %b after release, required 1", tready_a);
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL rstmid_no_resume: %0d active cycles, %0d bytes decoded, required 0 and 0",
               bad, rx_q.size());
    end
    exp_q.push_back({2'b11, 8'h00});
    send(1'b0, 8'h00, 1'b0, 1'b0, acc);
    wait_rx(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (rx_q.size() == 0) begin
        fails++;
        $display("FAIL rstmid_decode: no byte decoded, required %h", e);
      end else begin
        r = rx_q.pop_front();
        if (r !== e) begin
          fails++;
          $display("FAIL rstmid_decode: got %h, required %h", r, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_eol();
    test_no_eol();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
